// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_pkg                                                    |
// | Brief   : Shared ALU operation codes ({inst30,funct3}), execution-   |
// |           unit state encoding and small decode helpers. Usable by    |
// |           both ALU_control and alu_exec_unit.                        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_pkg;

    // Operation codes as produced by ALU_control: {inst30, funct3}
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // Execution-unit control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_e;

    // True for the three shift operations
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shift_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_shift_iter                                             |
// | Brief   : One-bit-per-cycle shifter. Loaded on start_i with operand, |
// |           amount and direction; advances one position per step_i.    |
// |           data_next_o is the value after the current step, last_o    |
// |           flags that the current step is the final one.              |
// |           Not instantiated when ALU_FAST_SHIFT_EN is defined.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_shift_iter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  amt_i,
    input  logic            right_i,
    input  logic            arith_i,
    output logic [XLEN-1:0] data_next_o,
    output logic            last_o
);

    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  cnt_q;
    logic            right_q;
    logic            arith_q;

    // Single-position shift of the working register; SRA refills with the sign bit
    assign data_next_o = right_q ? {(arith_q & data_q[XLEN-1]), data_q[XLEN-1:1]}
                                 : {data_q[XLEN-2:0], 1'b0};
    assign last_o      = (cnt_q == SHW'(1));

    // Load on start, otherwise shift once and count down per step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            cnt_q   <= '0;
            right_q <= 1'b0;
            arith_q <= 1'b0;
        end else if (start_i) begin
            data_q  <= data_i;
            cnt_q   <= amt_i;
            right_q <= right_i;
            arith_q <= arith_i;
        end else if (step_i) begin
            data_q  <= data_next_o;
            cnt_q   <= cnt_q - SHW'(1);
        end
    end

endmodule : alu_shift_iter
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_exec_unit                                              |
// | Brief   : Handshaked RV32-style ALU execution unit with registered   |
// |           result/zero flag. Non-shift ops complete in one cycle;     |
// |           shifts by N>0 take N+1 cycles through alu_shift_iter.      |
// |           Macro ALU_FAST_SHIFT_EN: when defined, shifts use a        |
// |           combinational barrel shifter and every op has latency 1.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);
    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    logic            accept_d;
    logic            iter_shift_d;
    logic [XLEN-1:0] imm_res_d;
    logic [XLEN-1:0] shift_next_d;
    logic            shift_last_d;

    // Single-cycle result. In the iterative build a shift only reaches this
    // path with amount 0, so the operand passes through unchanged.
    function automatic logic [XLEN-1:0] alu_eval(input logic [3:0]      op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
`endif
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
`else
            OP_SLL, OP_SRL, OP_SRA: return a;
`endif
            default: return '0;
        endcase
    endfunction

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign accept_d  = in_valid && in_ready;
    assign imm_res_d = alu_eval(alu_op, op_a, op_b);
    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign zero      = zero_q;

`ifdef ALU_FAST_SHIFT_EN
    assign iter_shift_d = 1'b0;
    assign shift_next_d = '0;
    assign shift_last_d = 1'b0;
    assign busy         = 1'b0;
`else
    logic [SHW-1:0] amt_d;

    assign amt_d        = op_b[SHW-1:0];
    assign iter_shift_d = is_shift_op(alu_op) && (amt_d != '0);
    assign busy         = (state_q == ST_SHIFT);

    alu_shift_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shift_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (accept_d && iter_shift_d),
        .step_i      (state_q == ST_SHIFT),
        .data_i      (op_a),
        .amt_i       (amt_d),
        .right_i     (alu_op != OP_SLL),
        .arith_i     (alu_op == OP_SRA),
        .data_next_o (shift_next_d),
        .last_o      (shift_last_d)
    );
`endif

    // Control FSM with registered result and zero flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept_d) begin
                        if (iter_shift_d) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q  <= ST_HOLD;
                            result_q <= imm_res_d;
                            zero_q   <= (imm_res_d == '0);
                        end
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last_d) begin
                        state_q  <= ST_HOLD;
                        result_q <= shift_next_d;
                        zero_q   <= (shift_next_d == '0);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_exec_unit                                           |
// | Brief   : Self-checking bench for alu_exec_unit (XLEN=32): vector    |
// |           table plus backpressure, back-to-back and mid-shift reset  |
// |           sequences. Honours ALU_FAST_SHIFT_EN for latencies.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic z,
                           input int lat_iter);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z;
`ifdef ALU_FAST_SHIFT_EN
        v.lat = 1;
`else
        v.lat = lat_iter;
`endif
        vecs.push_back(v);
    endtask

    // Issue one op from IDLE, keep garbage offered while waiting, check, then drain
    task automatic run_op(input vec_t v);
        int lat;
        int nbusy;
        @(negedge clk);
        in_valid = 1'b1; alu_op = v.op; op_a = v.a; op_b = v.b;
        @(negedge clk);
        alu_op = 4'b0000; op_a = ~v.a; op_b = 32'h5555_5555;
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_lat"},  32'(lat), 32'(v.lat));
        chk({v.name, "_busy"}, 32'(nbusy), 32'(v.lat - 1));
        chk({v.name, "_res"},  result, v.res);
        chk({v.name, "_zero"}, {31'b0, zero}, {31'b0, v.z});
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 4'b0000; op_a = '0; op_b = '0;

        add_vec("add_ovf",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1);
        add_vec("sub_eq",    4'b1000, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1);
        add_vec("sub_wrap",  4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
        add_vec("sltu_1",    4'b0011, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        add_vec("slt_0",     4'b0010, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
        add_vec("slt_neg",   4'b0010, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        add_vec("sltu_big",  4'b0011, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        add_vec("xor",       4'b0100, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 1);
        add_vec("or",        4'b0110, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 1'b0, 1);
        add_vec("and",       4'b0111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0204_0608, 1'b0, 1);
        add_vec("unknown",   4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        add_vec("sll_mask0", 4'b0001, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 1);
        add_vec("sra_neg4",  4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5);
        add_vec("srl_3",     4'b0101, 32'h8000_0001, 32'h0000_0003, 32'h1000_0000, 1'b0, 4);
        add_vec("sll_31",    4'b0001, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 32);
        add_vec("sra_pos1",  4'b1101, 32'h4000_0000, 32'h0000_0021, 32'h2000_0000, 1'b0, 2);
        add_vec("sll_out",   4'b0001, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_result",    result,             32'd0);
        chk("rst_zero",      {31'b0, zero},      32'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: result held stable while out_ready stays low
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b0000; op_a = 32'd5; op_b = 32'd6;
        @(negedge clk);
        in_valid = 1'b0; op_a = 32'd100;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd11);
            @(negedge clk);
        end
        chk("bp_still", result, 32'd11);
        // Back-to-back: drain and accept in the same HOLD cycle
        out_ready = 1'b1; in_valid = 1'b1;
        alu_op = 4'b0111; op_a = 32'h0000_00FF; op_b = 32'h0000_000F;
        @(negedge clk);
        chk("b2b_valid",  {31'b0, out_valid}, 32'd1);
        chk("b2b_result", result, 32'h0000_000F);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("b2b_idle_ready", {31'b0, in_ready},  32'd1);

        // Reset in the middle of a long shift
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b0001; op_a = 32'h0000_0001; op_b = 32'd31;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid",  {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ready",  {31'b0, in_ready},  32'd1);
        chk("mid_rst_busy",   {31'b0, busy},      32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_out", {31'b0, out_valid}, 32'd0);

        // Operations after reset still correct
        v.name = "post_add"; v.op = 4'b0000; v.a = 32'd40; v.b = 32'd2;
        v.res = 32'd42; v.z = 1'b0; v.lat = 1;
        run_op(v);
        v.name = "post_srl"; v.op = 4'b0101; v.a = 32'hF000_0000; v.b = 32'd2;
        v.res = 32'h3C00_0000; v.z = 1'b0;
`ifdef ALU_FAST_SHIFT_EN
        v.lat = 1;
`else
        v.lat = 3;
`endif
        run_op(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width (power of two, >=8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation offered.
REQ-005 SHALL have port in_ready  output  1  unit can accept an operation this cycle.
REQ-006 SHALL have port alu_op  input  4  operation code {inst30,funct3} as produced by ALU_control.
REQ-007 SHALL have ports op_a, op_b  input  XLEN  source operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port result  output  XLEN  registered result.
REQ-011 SHALL have port zero  output  1  registered (result == 0), used by branch logic.
REQ-012 SHALL have port busy  output  1  high while in SHIFT state.

Function
REQ-013 SHALL decode alu_op: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; any other code yields result 0.
REQ-014 SHALL use modulo-2^XLEN add/sub; SLT/SLTU produce 1 or 0 zero-extended to XLEN.
REQ-015 SHALL take the shift amount from op_b[log2(XLEN)-1:0]; upper bits ignored.
REQ-016 SHALL implement states IDLE, SHIFT, HOLD; out_valid = (state == HOLD).
REQ-017 SHALL drive in_ready = (state == IDLE) or (state == HOLD and out_ready).
REQ-018 SHALL accept an operation in the cycle in_valid and in_ready are both high, capturing alu_op/op_a/op_b.
REQ-019 SHALL, for non-shift ops, unknown codes or shift amount 0, enter HOLD the cycle after accept (latency 1).
REQ-020 SHALL, for shifts with amount N>0 (iterative build), enter SHIFT, move one bit per cycle, and enter HOLD after exactly N SHIFT cycles (latency N+1); SRA replicates the sign bit.
REQ-021 SHALL keep result and zero stable in HOLD until out_ready is sampled high.
REQ-022 SHALL, on out_ready in HOLD without a new accept, return to IDLE; with simultaneous accept, load the new operation (back-to-back, no bubble).
REQ-023 SHALL ignore in_valid in SHIFT (in_ready low); input changes during SHIFT do not affect the result.
REQ-024 SHALL ignore out_ready outside HOLD.

Reset
REQ-025 SHALL, when rst_n is low at a clock edge, enter IDLE and clear result, zero-flag register, shift counter; out_valid=0, busy=0, in_ready=1 the following cycle.
REQ-026 SHALL abort any shift or held result on reset; no result is produced for the aborted operation.

Configuration
REQ-027 SHALL honour macro ALU_FAST_SHIFT_EN: defined -> shifts computed combinationally, latency 1 for all ops, SHIFT state never entered, busy tied 0; undefined -> iterative shifting per REQ-020.
REQ-028 SHALL produce bit-identical results with and without ALU_FAST_SHIFT_EN; only latency differs.

Structure
REQ-029 SHALL place alu_op code constants and the state encoding in shared package alu_pkg, also usable by ALU_control.
REQ-030 SHALL isolate the iterative shifter (data register, counter, direction/arith control) in sub-module alu_shift_iter, omitted when ALU_FAST_SHIFT_EN is defined.

Verification
REQ-031 SHALL cover ADD: op_a=0x7FFFFFFF, op_b=1, op 0000 -> out_valid 1 cycle after accept, result 0x80000000, zero=0.
REQ-032 SHALL cover SUB equal: op_a=op_b=0x1234, op 1000 -> result 0, zero=1; SLTU op_a=1, op_b=0xFFFFFFFF -> 1; SLT same operands -> 0.
REQ-033 SHALL cover SRA iterative: op_a=0x80000000, op_b=4, op 1101 -> busy 4 cycles, out_valid at accept+5, result 0xF8000000; with macro, out_valid at accept+1.
REQ-034 SHALL cover backpressure/back-to-back: out_ready low 3 cycles holds result stable; out_ready and in_valid high together in HOLD -> next result at following cycle, no gap.
REQ-035 SHALL cover reset mid-shift: SLL by 31 accepted, rst_n low on cycle 3 -> next cycle out_valid=0, result=0, in_ready=1; later ops correct.
REQ-036 SHALL cover unknown code 1111 and shift amount op_b=0x20 (masked to 0) -> result 0 / op_a unchanged respectively, latency 1.
